// File: rtl/kernel_select_ctrl.sv
// kernel_select_ctrl: sequences kernel changes for the 7x7 convolution datapath.
//
// The pending kernel index is tracked from debounced next/prev pushbuttons or from the
// switches. A new index is committed to the coefficient LUT only at a frame boundary,
// once the convolution pipeline has drained. The LUT output is then held for
// SETTLE_CYCLES before a one-cycle coef_load strobe, so the datapath latches kernel and
// divisor together and no frame is ever filtered with mixed coefficients.
//
// Ports:
//   clk_i            system clock
//   resetn_i         asynchronous active-low reset
//   key_next_n_i     raw "next kernel" pushbutton, active-low, asynchronous
//   key_prev_n_i     raw "previous kernel" pushbutton, active-low, asynchronous
//   direct_mode_i    1: pending index follows sw_select_i; 0: follows buttons
//   sw_select_i      direct kernel index from switches
//   frame_start_i    one-cycle pulse at start of vertical blank
//   pipe_idle_i      line buffers and multiply tree are empty
//   select_o         kernel index driven to the LUT
//   coef_load_o      one-cycle strobe; datapath latches kernel/divisor
//   busy_o           high whenever a commit is being sequenced
//   pending_sel_o    index queued for the next commit (on-screen display)
module kernel_select_ctrl #(
    parameter int unsigned NUM_KERNELS     = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned SETTLE_CYCLES   = 2
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       key_next_n_i,
    input  logic       key_prev_n_i,
    input  logic       direct_mode_i,
    input  logic [3:0] sw_select_i,
    input  logic       frame_start_i,
    input  logic       pipe_idle_i,
    output logic [3:0] select_o,
    output logic       coef_load_o,
    output logic       busy_o,
    output logic [3:0] pending_sel_o
);

    localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [CntW-1:0]    CntMax    = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SettleW-1:0] SettleMax = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         MaxIdx    = 4'(NUM_KERNELS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitFrame,
        StDrain,
        StSettle,
        StLoad
    } state_e;

    // ------------------------------------------------------------------
    // Key synchronisation and debounce. Bit 0 = next key, bit 1 = prev key.
    // ------------------------------------------------------------------
    logic [1:0]           keys_raw;
    logic [1:0]           sync1_q, sync2_q, prev_q;
    logic [1:0]           stable_q, stable_d;
    logic [1:0][CntW-1:0] cnt_q, cnt_d;
    logic [1:0]           press;

    assign keys_raw = {key_prev_n_i, key_next_n_i};

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        press    = '0;
        for (int k = 0; k < 2; k++) begin
            // Any change of the synchronised level restarts the stability count.
            if (sync2_q[k] != prev_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] != CntMax) begin
                cnt_d[k] = cnt_q[k] + CntW'(1);
            end
            if (cnt_q[k] == CntMax) begin
                stable_d[k] = prev_q[k];
            end
            // Single pulse on the accepted release->press edge only.
            press[k] = stable_q[k] & ~stable_d[k];
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            prev_q   <= 2'b11;
            stable_q <= 2'b11;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= keys_raw;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pending index, updated every cycle regardless of FSM state.
    // ------------------------------------------------------------------
    logic [3:0] pend_q, pend_d;
    logic       next_ev, prev_ev;

    assign next_ev = press[0];
    assign prev_ev = press[1];

    always_comb begin
        pend_d = pend_q;
        if (direct_mode_i) begin
            pend_d = (32'(sw_select_i) >= NUM_KERNELS) ? 4'd0 : sw_select_i;
        end else if (next_ev && !prev_ev) begin
            pend_d = (pend_q == MaxIdx) ? 4'd0 : pend_q + 4'd1;
        end else if (prev_ev && !next_ev) begin
            pend_d = (pend_q == 4'd0) ? MaxIdx : pend_q - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Commit sequencer.
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [3:0]           sel_q, sel_d;
    logic [SettleW-1:0]   settle_q, settle_d;
    logic                 coef_load_q, coef_load_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        settle_d = settle_q;
        case (state_q)
            StIdle: begin
                if (pend_q != sel_q) begin
                    state_d = StWaitFrame;
                end
            end
            StWaitFrame: begin
                // A pending change that was undone before the boundary needs no load.
                if (pend_q == sel_q) begin
                    state_d = StIdle;
                end else if (frame_start_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (pipe_idle_i) begin
                    sel_d    = pend_q;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == SettleMax) begin
                    state_d = StLoad;
                end else begin
                    settle_d = settle_q + SettleW'(1);
                end
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Outputs are registered, so they are derived from the next state.
        coef_load_d = (state_d == StLoad);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            settle_q    <= '0;
            pend_q      <= '0;
            coef_load_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            settle_q    <= settle_d;
            pend_q      <= pend_d;
            coef_load_q <= coef_load_d;
            busy_q      <= busy_d;
        end
    end

    assign select_o      = sel_q;
    assign coef_load_o   = coef_load_q;
    assign busy_o        = busy_q;
    assign pending_sel_o = pend_q;

endmodule

// File: doc/kernel_select_ctrl.md
Name: kernel_select_ctrl

Overview:
- Sequences kernel changes for the 7x7 convolution datapath: debounces next/previous pushbuttons, or takes a direct switch selection, and tracks the pending kernel index.
- Commits a new 4-bit kernel select to the kernel coefficient LUT only at a frame boundary, after the convolution pipeline has drained.
- Pulses a coefficient-load strobe so the datapath registers the new 392-bit kernel and divisor atomically. No frame is ever filtered with mixed coefficients.

Parameters:
- NUM_KERNELS, 10, number of valid LUT entries; indices 0..NUM_KERNELS-1.
- DEBOUNCE_CYCLES, 20'd1000000, clk cycles a key must be stable before it is accepted.
- SETTLE_CYCLES, 2, cycles the LUT output is held stable before coef_load.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- key_next_n  input  1  raw pushbutton, active-low, asynchronous to clk
- key_prev_n  input  1  raw pushbutton, active-low, asynchronous to clk
- direct_mode  input  1  1: use sw_select; 0: use buttons
- sw_select  input  4  direct kernel index from switches
- frame_start  input  1  one-cycle pulse at start of vertical blank
- pipe_idle  input  1  convolution line buffers and multiply tree empty
- select  output  4  kernel index driven to the LUT
- coef_load  output  1  one-cycle strobe; datapath latches kernel/divisor
- busy  output  1  high in any state other than IDLE
- pending_sel  output  4  index queued for the next commit, for on-screen display

Behaviour:
- Reset (async, resetn=0):
  - select=0 (identity), pending_sel=0, coef_load=0, busy=0.
  - State IDLE; debounce counters cleared.
  - Synchronizer flops set to 1 (key released).
- Key inputs:
  - Each key passes through a 2-flop synchronizer, then a debounce counter that resets on any change of the synchronized level.
  - The level is accepted when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a single pulse on the accepted 1->0 transition; holding a key produces no repeats.
- pending_sel update (every cycle, in any state):
  - direct_mode=1: pending_sel = sw_select, or 0 if sw_select >= NUM_KERNELS. Button events are ignored.
  - direct_mode=0:
    - next event: pending_sel+1, wrapping NUM_KERNELS-1 -> 0.
    - prev event: pending_sel-1, wrapping 0 -> NUM_KERNELS-1.
    - next and prev events in the same cycle: no change.
- FSM states: IDLE, WAIT_FRAME, DRAIN, SETTLE, LOAD.
  - IDLE: if pending_sel != select, go to WAIT_FRAME next cycle.
  - WAIT_FRAME:
    - On frame_start=1, go to DRAIN.
    - If pending_sel returns to equal select before the boundary, go back to IDLE with no load.
  - DRAIN:
    - When pipe_idle=1, capture select <= pending_sel, clear the settle counter, go to SETTLE.
    - pending_sel changes after this capture do not affect the commit in progress.
  - SETTLE: count SETTLE_CYCLES cycles, then go to LOAD.
  - LOAD: coef_load=1 for exactly one cycle, then go to IDLE.
- Edge cases:
  - If pending_sel changed during SETTLE/LOAD, IDLE re-detects the mismatch and the next frame boundary commits it (at most one commit per frame).
  - frame_start in a state other than WAIT_FRAME is ignored.
- Timing and stability:
  - Latency from the frame_start pulse (pipe_idle already 1) to coef_load is SETTLE_CYCLES+2 cycles.
  - select changes only on the DRAIN->SETTLE transition and is stable for at least SETTLE_CYCLES+1 cycles before and during coef_load.
- Reset asserted mid-sequence: immediate return to the reset values. select reverts to identity; no coef_load is emitted.
- All outputs are registered.

Test Plan:
- Reset state: hold resetn=0 for 5 cycles then release, no stimulus → select=0, pending_sel=0, busy=0, coef_load never asserts.
- Button next, with DEBOUNCE_CYCLES=4 for sim:
  - Press key_next_n for 10 cycles with 2 glitch cycles at the start → exactly one event, pending_sel=1.
  - frame_start with pipe_idle=1 → select=1 and a single coef_load exactly 4 cycles after frame_start.
- Wrap-around:
  - From pending_sel=9, one next press → 0.
  - From pending_sel=0, one prev press → 9.
  - A simultaneous next+prev event → unchanged.
- Drain hold: pending_sel=5, frame_start while pipe_idle=0 for 30 cycles → select stays unchanged and busy=1 until pipe_idle rises; then select=5 and coef_load follows SETTLE_CYCLES+1 cycles later.
- Direct mode:
  - direct_mode=1, sw_select=12 → pending_sel=0, no commit if select=0.
  - sw_select=7 → commit 7 at the next frame_start.
  - Toggling sw_select 7->0 before the boundary, with select=0 → return to IDLE, no coef_load.
- Mid-operation reset: assert resetn=0 during SETTLE with select=3 pending → select=0 immediately, no coef_load after release.
